// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the unified memory-port arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Identity of the requester that owns the current transaction
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

    // All four byte lanes enabled (word access and every load)
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Sign-extend one byte to a full 32-bit word (lb result)
    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Little-endian byte-lane steering between the CPU data path and the
// 32-bit memory bus: store byte enables, store data replication and
// load byte extraction with sign extension.
module mem_byte_lane
    import mem_arb_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic        byte_op,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_fmt,
    output logic [31:0] load_fmt
);

    logic [7:0] rd_byte;

    // Steer byte lanes: only byte stores narrow the enables, loads read the full word
    always_comb begin
        be        = BE_WORD;
        wdata_fmt = wdata;
        load_fmt  = rdata;
        rd_byte   = rdata[{lane, 3'b000} +: 8];
        if (byte_op && we) begin
            be = 4'b0001 << lane;
        end
        if (byte_op) begin
            wdata_fmt = {4{wdata[7:0]}};
            load_fmt  = sext8(rd_byte);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and data
// accesses of the multi-cycle CPU. Data has priority, but after
// MAX_D_STREAK back-to-back data grants with fetch waiting, fetch is
// forced through. Each transaction runs IDLE -> BUSY -> RESP, with the
// completion ack registered out of RESP so it appears in the following
// IDLE cycle. Misaligned word/fetch accesses skip memory entirely, and a
// memory that never answers is abandoned after TIMEOUT BUSY cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT      = 15,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    localparam int              SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [7:0]      TO_LAST    = 8'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;

    // Transaction context captured at grant time
    logic              gnt;
    logic              err_pend;
    logic [1:0]        lane;
    logic              byte_op;
    logic [31:0]       rdata_hold;

    logic [SW-1:0]     streak;
    logic [7:0]        tcnt;

    // Arbitration and lane-steering nets
    logic              fetch_forced;
    logic              grant_d;
    logic              grant_any;
    logic [ADDR_W-1:0] win_addr;
    logic              win_we;
    logic              win_byte;
    logic              misalign;
    logic              timeout_hit;
    logic [1:0]        lane_sel;
    logic              byte_sel;
    logic [3:0]        be_fmt;
    logic [31:0]       wdata_fmt;
    logic [31:0]       load_fmt;

    // Pick the winner from live requests and qualify its alignment
    always_comb begin
        fetch_forced = if_req && (streak == STREAK_MAX);
        grant_d      = d_req && !fetch_forced;
        grant_any    = d_req || if_req;
        win_addr     = grant_d ? d_addr : if_addr;
        win_we       = grant_d && d_we;
        win_byte     = grant_d && d_byte;
        misalign     = !win_byte && (win_addr[1:0] != 2'b00);
        timeout_hit  = (tcnt == TO_LAST);
        // In IDLE the lane logic formats the incoming store; afterwards it
        // formats returning read data using the captured byte offset.
        lane_sel     = (state == IDLE) ? win_addr[1:0] : lane;
        byte_sel     = (state == IDLE) ? win_byte      : byte_op;
    end

    mem_byte_lane u_lane (
        .lane      (lane_sel),
        .byte_op   (byte_sel),
        .we        (win_we),
        .wdata     (d_wdata),
        .rdata     (mem_rdata),
        .be        (be_fmt),
        .wdata_fmt (wdata_fmt),
        .load_fmt  (load_fmt)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: grant, wait for memory or timeout, then one response cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_next = misalign ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (mem_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control, memory-port and completion registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= GNT_IF;
            err_pend  <= 1'b0;
            streak    <= '0;
            tcnt      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (grant_any) begin
                        gnt      <= grant_d ? GNT_D : GNT_IF;
                        err_pend <= misalign;
                        if (grant_d && if_req) begin
                            if (streak != STREAK_MAX) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                        if (!misalign) begin
                            mem_req   <= 1'b1;
                            mem_we    <= win_we;
                            mem_be    <= be_fmt;
                            mem_addr  <= {win_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata <= wdata_fmt;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        err_pend <= 1'b0;
                    end else if (timeout_hit) begin
                        mem_req  <= 1'b0;
                        err_pend <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                RESP: begin
                    err <= err_pend;
                    if (gnt == GNT_D) begin
                        d_ack   <= 1'b1;
                        d_rdata <= rdata_hold;
                    end else begin
                        if_ack   <= 1'b1;
                        if_rdata <= rdata_hold;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data context: byte offset at grant, formatted read word at completion
    // (zero for misaligned or timed-out accesses)
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            lane    <= win_addr[1:0];
            byte_op <= win_byte;
        end
        rdata_hold <= (state == BUSY && mem_ready) ? load_fmt : 32'd0;
    end

endmodule
